piso_tx_arbiter: RTL

PISO_TX_ARBITER -- requirements
Module: piso_tx_arbiter

---
 rtl/piso_tx_arbiter.sv | 135 +++++++++++++
 1 files changed

// File: rtl/piso_tx_arbiter.sv
// Two-requester round-robin arbiter feeding a parallel-in/serial-out shifter.
// Each grant produces a LOAD cycle, WIDTH shift cycles and GAP_CYCLES idle cycles.
module piso_tx_arbiter #(
  parameter int WIDTH      = 4,
  parameter int GAP_CYCLES = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req_a,
  input  logic [WIDTH-1:0] data_a,
  input  logic             req_b,
  input  logic [WIDTH-1:0] data_b,
  output logic             ack_a,
  output logic             ack_b,
  output logic             piso_load,
  output logic [WIDTH-1:0] piso_pin,
  output logic             tx_active,
  output logic             tx_src,
  output logic [3:0]       bit_cnt,
  output logic             done
);

  // Out-of-range gap settings are clamped so the 4-bit gap counter always terminates.
  localparam int         GAP_N    = (GAP_CYCLES < 1) ? 1 : ((GAP_CYCLES > 15) ? 15 : GAP_CYCLES);
  localparam logic [3:0] LAST_BIT = 4'(WIDTH - 1);
  localparam logic [3:0] GAP_LAST = 4'(GAP_N - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    GAP   = 2'd3
  } state_t;

  state_t           state, state_nx;
  logic [3:0]       gap_cnt, gap_cnt_nx;
  logic             last_b, last_b_nx;

  logic             ack_a_nx, ack_b_nx, load_nx, active_nx, done_nx, src_nx;
  logic [3:0]       bit_cnt_nx;
  logic [WIDTH-1:0] pin_nx;

  logic             grant_any;
  logic             win_b;

  // B wins when it is alone, or when both request and A was served last.
  assign grant_any = req_a | req_b;
  assign win_b     = req_b & (~req_a | ~last_b);

  always_comb begin
    state_nx   = state;
    gap_cnt_nx = gap_cnt;
    last_b_nx  = last_b;
    ack_a_nx   = 1'b0;
    ack_b_nx   = 1'b0;
    load_nx    = 1'b0;
    active_nx  = 1'b0;
    done_nx    = 1'b0;
    bit_cnt_nx = 4'd0;
    pin_nx     = piso_pin;
    src_nx     = tx_src;

    case (state)
      IDLE: begin
        if (grant_any) begin
          state_nx  = LOAD;
          load_nx   = 1'b1;
          ack_a_nx  = ~win_b;
          ack_b_nx  = win_b;
          pin_nx    = win_b ? data_b : data_a;
          src_nx    = win_b;
          last_b_nx = win_b;
        end
      end

      LOAD: begin
        state_nx   = SHIFT;
        active_nx  = 1'b1;
        bit_cnt_nx = 4'd0;
        done_nx    = (LAST_BIT == 4'd0);
      end

      SHIFT: begin
        if (bit_cnt == LAST_BIT) begin
          state_nx   = GAP;
          gap_cnt_nx = 4'd0;
        end else begin
          active_nx  = 1'b1;
          bit_cnt_nx = bit_cnt + 4'd1;
          done_nx    = ((bit_cnt + 4'd1) == LAST_BIT);
        end
      end

      GAP: begin
        if (gap_cnt == GAP_LAST) begin
          state_nx = IDLE;
        end else begin
          gap_cnt_nx = gap_cnt + 4'd1;
        end
      end

      default: state_nx = IDLE;
    endcase
  end

  // Every output is a register loaded with the value for the state being entered.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      gap_cnt   <= 4'd0;
      last_b    <= 1'b1;
      ack_a     <= 1'b0;
      ack_b     <= 1'b0;
      piso_load <= 1'b0;
      piso_pin  <= '0;
      tx_active <= 1'b0;
      tx_src    <= 1'b0;
      bit_cnt   <= 4'd0;
      done      <= 1'b0;
    end else begin
      state     <= state_nx;
      gap_cnt   <= gap_cnt_nx;
      last_b    <= last_b_nx;
      ack_a     <= ack_a_nx;
      ack_b     <= ack_b_nx;
      piso_load <= load_nx;
      piso_pin  <= pin_nx;
      tx_active <= active_nx;
      tx_src    <= src_nx;
      bit_cnt   <= bit_cnt_nx;
      done      <= done_nx;
    end
  end

endmodule
